// File: rtl/alu_seq_pkg.sv
// Shared types and decode helpers for the ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned AluOpW = 15;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpCmp, OpAnd, OpOr, OpXor, OpNot, OpNeg,
    OpShl, OpShr, OpSt, OpLd, OpMov, OpLdump, OpSdump, OpIllegal
  } opcode_e;

  typedef enum logic [1:0] {StIdle, StExec, StMem, StWb} state_e;

  // Bit positions of the one-hot ALU strobes
  localparam int unsigned AluBitAdd   = 0;
  localparam int unsigned AluBitSub   = 1;
  localparam int unsigned AluBitCmp   = 2;
  localparam int unsigned AluBitAnd   = 3;
  localparam int unsigned AluBitOr    = 4;
  localparam int unsigned AluBitXor   = 5;
  localparam int unsigned AluBitNot   = 6;
  localparam int unsigned AluBitNeg   = 7;
  localparam int unsigned AluBitShl   = 8;
  localparam int unsigned AluBitShr   = 9;
  localparam int unsigned AluBitSt    = 10;
  localparam int unsigned AluBitLd    = 11;
  localparam int unsigned AluBitMov   = 12;
  localparam int unsigned AluBitLdump = 13;
  localparam int unsigned AluBitSdump = 14;

  function automatic logic [AluOpW-1:0] op_onehot(opcode_e op);
    logic [AluOpW-1:0] oh;
    oh = '0;
    unique case (op)
      OpAdd:   oh[AluBitAdd]   = 1'b1;
      OpSub:   oh[AluBitSub]   = 1'b1;
      OpCmp:   oh[AluBitCmp]   = 1'b1;
      OpAnd:   oh[AluBitAnd]   = 1'b1;
      OpOr:    oh[AluBitOr]    = 1'b1;
      OpXor:   oh[AluBitXor]   = 1'b1;
      OpNot:   oh[AluBitNot]   = 1'b1;
      OpNeg:   oh[AluBitNeg]   = 1'b1;
      OpShl:   oh[AluBitShl]   = 1'b1;
      OpShr:   oh[AluBitShr]   = 1'b1;
      OpSt:    oh[AluBitSt]    = 1'b1;
      OpLd:    oh[AluBitLd]    = 1'b1;
      OpMov:   oh[AluBitMov]   = 1'b1;
      OpLdump: oh[AluBitLdump] = 1'b1;
      OpSdump: oh[AluBitSdump] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

  // Arithmetic/logic ops (ADD..SHR) are the only ones that touch Z/C/N
  function automatic logic writes_flags(opcode_e op);
    return op <= OpShr;
  endfunction

  function automatic logic is_load_op(opcode_e op);
    return (op == OpLd) || (op == OpLdump);
  endfunction

  function automatic logic is_store_op(opcode_e op);
    return (op == OpSt) || (op == OpSdump);
  endfunction

  function automatic logic is_mem_op(opcode_e op);
    return is_load_op(op) || is_store_op(op);
  endfunction

  function automatic logic writes_reg(opcode_e op);
    return (writes_flags(op) && (op != OpCmp)) || (op == OpMov) || is_load_op(op);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x 16 register file: two async read ports, one sync write port.
module alu_seq_regfile #(
  parameter int unsigned NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  output logic [15:0]              o_rdata_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  output logic [15:0]              o_rdata_b,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [15:0]              i_wdata
);

  logic [15:0] r_mem [NREGS];

  // Storage: cleared on reset, written on the write-back edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving the 16-bit ALU and data-memory port.
// Optional MEM-state timeout abort: define ALU_SEQ_CTRL_TIMEOUT_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs,
  input  logic [15:0]              in_imm,
  input  logic                     in_use_imm,
  output logic [15:0]              alu_r1,
  output logic [15:0]              alu_r2,
  output logic [AluOpW-1:0]        alu_op,
  input  logic [16:0]              alu_result,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [15:0]              mem_rdata,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     flag_n,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IdxW = $clog2(NREGS);

  state_e            r_state;
  opcode_e           r_op;
  logic [IdxW-1:0]   r_rd;
  logic [15:0]       r_alu_r1, r_alu_r2;
  logic [AluOpW-1:0] r_alu_op;
  logic [16:0]       r_res;
  logic [15:0]       r_rdata;
  logic              r_mem_req, r_mem_we;
  logic [15:0]       r_mem_addr, r_mem_wdata;
  logic              r_z, r_c, r_n, r_done, r_err;

  opcode_e     w_in_op;
  logic [15:0] w_rd_data, w_rs_data, w_wb_data;
  logic        w_wb_we;

  assign w_in_op   = opcode_e'(in_op);
  assign w_wb_we   = (r_state == StWb) && writes_reg(r_op);
  assign w_wb_data = is_load_op(r_op) ? r_rdata : r_res[15:0];

  alu_seq_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr_a(in_rd),
    .o_rdata_a(w_rd_data),
    .i_raddr_b(in_rs),
    .o_rdata_b(w_rs_data),
    .i_we     (w_wb_we),
    .i_waddr  (r_rd),
    .i_wdata  (w_wb_data)
  );

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
  logic [TmoW-1:0] r_tmo_cnt;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (MEM_TIMEOUT != 0);
`endif

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op        <= OpAdd;
      r_rd        <= '0;
      r_alu_r1    <= '0;
      r_alu_r2    <= '0;
      r_alu_op    <= '0;
      r_res       <= '0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            if (w_in_op == OpIllegal) begin
              // Illegal opcode retires immediately with no other effect
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_op     <= w_in_op;
              r_rd     <= in_rd;
              r_alu_r1 <= w_rd_data;
              r_alu_r2 <= in_use_imm ? in_imm : w_rs_data;
              r_alu_op <= op_onehot(w_in_op);
              r_state  <= StExec;
            end
          end
        end
        StExec: begin
          r_res    <= alu_result;
          r_alu_op <= '0;
          r_alu_r1 <= '0;
          r_alu_r2 <= '0;
          if (is_mem_op(r_op)) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= is_store_op(r_op);
            r_mem_addr  <= alu_result[15:0];
            // r_alu_r1 still holds reg[rd] sampled at accept
            r_mem_wdata <= is_store_op(r_op) ? r_alu_r1 : 16'h0;
            r_state     <= StMem;
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else begin
            r_done  <= 1'b1;
            r_state <= StWb;
          end
        end
        StMem: begin
          if (mem_ack) begin
            if (!r_mem_we) r_rdata <= mem_rdata;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b1;
            r_state     <= StWb;
          end
`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
          else if (r_tmo_cnt == TmoW'(MEM_TIMEOUT - 1)) begin
            // Abort: skip WB entirely so rd keeps its old value
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= StIdle;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        StWb: begin
          if (writes_flags(r_op)) begin
            r_z <= (r_res[15:0] == 16'h0);
            r_c <= r_res[16];
            r_n <= r_res[15];
          end
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign alu_r1    = r_alu_r1;
  assign alu_r2    = r_alu_r2;
  assign alu_op    = r_alu_op;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_n    = r_n;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and reference model.
module tb_alu_seq_ctrl;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_use_imm;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs;
  logic [15:0] in_imm;
  logic [15:0] alu_r1, alu_r2;
  logic [14:0] alu_op;
  logic [16:0] alu_result;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        flag_z, flag_c, flag_n, done, err;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [15:0] m_reg [8];
  logic        m_z, m_c, m_n, m_err;

  alu_seq_ctrl #(
    .NREGS      (8),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_imm    (in_imm),
    .in_use_imm(in_use_imm),
    .alu_r1    (alu_r1),
    .alu_r2    (alu_r2),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: op index is the opcode value; memory ops pass R2 through as address
  function automatic logic [16:0] alu_fn(int op, logic [15:0] a, logic [15:0] b);
    case (op)
      0:       return {1'b0, a} + {1'b0, b};
      1, 2:    return {1'b0, a} - {1'b0, b};
      3:       return {1'b0, a & b};
      4:       return {1'b0, a | b};
      5:       return {1'b0, a ^ b};
      6:       return {1'b0, ~a};
      7:       return 17'd0 - {1'b0, a};
      8:       return {a, 1'b0};
      9:       return {a[0], 1'b0, a[15:1]};
      default: return {1'b0, b};
    endcase
  endfunction

  int alu_idx;
  always_comb begin
    alu_idx = 15;
    for (int i = 0; i < 15; i++) if (alu_op[i]) alu_idx = i;
    alu_result = (alu_op == 15'h0) ? 17'h0 : alu_fn(alu_idx, alu_r1, alu_r2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_err = 1'b0;
  endtask

  // One full instruction from presentation to return to idle, checked every cycle
  task automatic run_instr(input logic [3:0] op, input int rd, input int rs,
                           input logic [15:0] imm, input logic use_imm,
                           input int ack_dly, input logic [15:0] rdata);
    logic [15:0] e1, e2;
    logic [16:0] res;
    logic        is_mem, is_st;
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_rd = 3'(rd); in_rs = 3'(rs);
    in_imm = imm; in_use_imm = use_imm;
    @(negedge clk);
    in_valid = 1'b0;
    if (op == 4'd15) begin
      m_err = 1'b1;
      chk("ill_done", done, 1);
      chk("ill_err", err, 1);
      chk("ill_no_strobe", alu_op, 0);
      @(negedge clk);
      chk("ill_done_low", done, 0);
      chk("ill_err_sticky", err, 1);
      return;
    end
    e1 = m_reg[rd];
    e2 = use_imm ? imm : m_reg[rs];
    chk("exec_op", alu_op, 32'(15'(1) << op));
    chk("exec_r1", alu_r1, e1);
    chk("exec_r2", alu_r2, e2);
    chk("exec_busy", in_ready, 0);
    chk("exec_done", done, 0);
    res    = alu_fn(int'(op), e1, e2);
    is_st  = (op == 4'd10) || (op == 4'd14);
    is_mem = is_st || (op == 4'd11) || (op == 4'd13);
    @(negedge clk);
    chk("strobe_clear", alu_op, 0);
    if (is_mem) begin
      for (int i = 0; i < ack_dly; i++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_addr", mem_addr, res[15:0]);
        chk("mem_we", mem_we, is_st);
        if (is_st) chk("mem_wdata", mem_wdata, e1);
        chk("mem_done", done, 0);
        if (i == ack_dly - 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 16'($urandom);
      end
    end
    chk("wb_done", done, 1);
    chk("wb_req", mem_req, 0);
    if (op inside {4'd0, 4'd1, [4'd3:4'd9], 4'd12}) m_reg[rd] = res[15:0];
    else if (op == 4'd11 || op == 4'd13) m_reg[rd] = rdata;
    if (op <= 4'd9) begin
      m_z = (res[15:0] == 16'h0); m_c = res[16]; m_n = res[15];
    end
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_ready", in_ready, 1);
    chk("flag_z", flag_z, m_z);
    chk("flag_c", flag_c, m_c);
    chk("flag_n", flag_n, m_n);
    chk("err", err, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0;
    in_imm = '0; in_use_imm = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_r1", alu_r1, 0);
    chk("rst_r2", alu_r2, 0);
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_flags", {flag_z, flag_c, flag_n, err, done}, 0);
    rst_n = 1'b1;

    // ADD 5 + 3, then use as operand to expose the written value
    run_instr(4'd12, 1, 0, 16'd5, 1'b1, 0, 0);
    run_instr(4'd0, 1, 0, 16'd3, 1'b1, 0, 0);
    run_instr(4'd4, 1, 1, 16'd0, 1'b0, 0, 0);
    // SUB 0 - 1 then CMP equal
    run_instr(4'd1, 5, 0, 16'd1, 1'b1, 0, 0);
    run_instr(4'd2, 5, 0, 16'hFFFF, 1'b1, 0, 0);
    // Store 0xBEEF to 0x10 with slow ack, then load it back
    run_instr(4'd12, 6, 0, 16'hBEEF, 1'b1, 0, 0);
    run_instr(4'd10, 6, 0, 16'h0010, 1'b1, 4, 0);
    run_instr(4'd11, 7, 0, 16'h0010, 1'b1, 2, 16'hBEEF);

    // Stray ack while idle
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'h1234;
    @(negedge clk); mem_ack = 1'b0;
    chk("stray_ack_req", mem_req, 0);
    chk("stray_ack_done", done, 0);
    run_instr(4'd3, 7, 7, 16'h0, 1'b0, 0, 0);

    // in_valid held through a busy instruction
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd12; in_rd = 3'd2; in_use_imm = 1'b1; in_imm = 16'd7;
    @(negedge clk);
    chk("hold_a_r2", alu_r2, 16'd7);
    in_rd = 3'd3; in_imm = 16'd9;
    @(negedge clk);
    chk("hold_wb_done", done, 1);
    chk("hold_wb_busy", in_ready, 0);
    m_reg[2] = 16'd7;
    @(negedge clk);
    chk("hold_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_b_op", alu_op, 32'(15'(1) << 12));
    chk("hold_b_r1", alu_r1, m_reg[3]);
    chk("hold_b_r2", alu_r2, 16'd9);
    @(negedge clk); @(negedge clk);
    m_reg[3] = 16'd9;
    run_instr(4'd5, 2, 3, 16'h0, 1'b0, 0, 0);

    // Illegal opcode
    run_instr(4'd15, 0, 0, 16'h0, 1'b0, 0, 0);
    run_instr(4'd12, 0, 2, 16'h0, 1'b0, 0, 0);

    // Reset while a load is outstanding; late ack must be ignored
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd11; in_rd = 3'd4; in_use_imm = 1'b1; in_imm = 16'h0020;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mid_flags", {flag_z, flag_c, flag_n, err, done}, 0);
    chk("rst_mid_ready", in_ready, 1);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk); mem_ack = 1'b0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_done", done, 0);
    run_instr(4'd0, 4, 1, 16'h0, 1'b0, 0, 0);
    run_instr(4'd0, 6, 7, 16'h0, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd15 && ($urandom_range(0, 3) != 0)) op = 4'd12;
      run_instr(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                16'($urandom), 1'($urandom), int'($urandom_range(1, 4)), 16'($urandom));
    end

`ifdef ALU_SEQ_CTRL_TIMEOUT_EN
    begin
      int cnt;
      cnt = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd11; in_rd = 3'd5; in_use_imm = 1'b1; in_imm = 16'h0040;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      while (mem_req && cnt < 1000) begin
        cnt++;
        @(negedge clk);
      end
      m_err = 1'b1;
      chk("tmo_cycles", cnt, TMO);
      chk("tmo_done", done, 1);
      chk("tmo_err", err, 1);
      @(negedge clk);
      chk("tmo_done_low", done, 0);
      run_instr(4'd4, 5, 5, 16'h0, 1'b0, 0, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that owns the 16-bit ALU datapath.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU's one-hot operation strobes and operands, captures the 17-bit result, and updates Z/C/N flags.
- Performs register write-back or a memory transaction. Sits between the instruction decoder and the ALU/data-memory port.

Parameters:
- NREGS, 8, register file depth (power of 2; index width = $clog2(NREGS)).
- MEM_TIMEOUT, 255, cycles to wait for mem_ack before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_op  in  4  opcode (package enum).
- in_rd  in  3  destination / first-operand register index.
- in_rs  in  3  second-operand register index.
- in_imm  in  16  immediate.
- in_use_imm  in  1  1: R2 = in_imm, 0: R2 = reg[in_rs].
- alu_r1, alu_r2  out  16  ALU operands.
- alu_op  out  15  one-hot strobes in order ADD,SUB,CMP,AND,OR,XOR,NOT,NEG,SHL,SHR,ST,LD,MOV,LDUMP,SDUMP.
- alu_result  in  17  ALU result.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  16  address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  16  read data, valid with mem_ack.
- flag_z, flag_c, flag_n  out  1  status flags.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  sticky error; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert as seen by logic):
  - State IDLE. All registers, flags and err are 0.
  - alu_op is 0; alu_r1/alu_r2 are 0.
  - mem_req, mem_we, mem_addr, mem_wdata and done are 0.
  - Reset mid-operation abandons the instruction with no write-back.
- Reset during an outstanding mem_req drops it immediately; a late mem_ack is ignored.
- State machine: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid&in_ready, latch op, rd, rs, imm and use_imm.
  - Opcode 15 is illegal: set err, pulse done next cycle, no other effect, return to IDLE.
- EXEC (1 cycle):
  - Drive the registered alu_r1 = reg[rd] and alu_r2 = selected R2, plus exactly one alu_op bit.
  - Capture alu_result into res[16:0] at the clock edge.
  - ST/LD/LDUMP/SDUMP go to MEM; all other ops go to WB.
- MEM:
  - mem_req = 1, held stable until the cycle mem_ack = 1.
  - mem_addr = res[15:0].
  - ST/SDUMP: mem_we = 1, mem_wdata = reg[rd].
  - LD/LDUMP: mem_we = 0; capture mem_rdata on ack.
  - mem_req drops the cycle after ack. mem_ack while not in MEM is ignored.
- WB (1 cycle), done = 1:
  - Register write for ADD,SUB,AND,OR,XOR,NOT,NEG,SHL,SHR,MOV: reg[rd] <= res[15:0].
  - LD/LDUMP: reg[rd] <= captured rdata.
  - CMP, ST, SDUMP: no register write.
- Flags update in WB only for ADD,SUB,CMP,AND,OR,XOR,NOT,NEG,SHL,SHR:
  - Z = (res[15:0]==0).
  - C = res[16].
  - N = res[15].
  - Other ops preserve the flags.
- Latency: non-memory ops retire 3 cycles after the accept edge (accept, EXEC, WB). Memory ops take 3 + ack wait.
- Throughput: at most one instruction in flight. in_ready = 0 from the accept edge until back in IDLE.
- Register read-after-write: the next instruction, accepted the cycle after WB, sees the written value. No bypass is needed because accept follows WB.
- Simultaneous in_valid during non-IDLE states: ignored, instruction stays pending at the source.

Optional Feature:
- ALU_SEQ_CTRL_TIMEOUT_EN defined:
  - An 8+ bit counter runs in MEM. When it reaches MEM_TIMEOUT without ack: drop mem_req, set err, skip write-back, pulse done, return to IDLE.
  - A load's rd is unchanged on timeout.
- Undefined: MEM waits indefinitely; no counter logic is present.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode_e (ADD=0..SDUMP=14, ILLEGAL=15).
  - state_e (IDLE, EXEC, MEM, WB).
  - the alu_op bit-position constants.
  - a function opcode->one-hot.
  - a function writes_flags(op).
- One natural sub-module: alu_seq_regfile (NREGS x 16, two async read ports, one sync write port, async reset to 0).

Test Plan:
- Reset, then ADD r1=5 (via prior MOV imm 5), r2 imm 3 -> alu_op[0] high one cycle; after WB, reg[rd]=8; Z=0,C=0,N=0; done 3 cycles after accept.
- SUB r1=0, imm 1 -> reg=0xFFFF, C=1, N=1, Z=0. Then CMP reg 0xFFFF vs imm 0xFFFF -> Z=1, reg unchanged.
- ST reg[rd]=0xBEEF, addr imm 0x0010; mem_ack delayed 4 cycles -> mem_req/addr/wdata/we stable 4 cycles; no reg change; flags unchanged.
- LD addr 0x0010, ack returns 0xBEEF -> reg[rd]=0xBEEF. Pulse mem_ack while IDLE -> no effect.
- in_valid held high through a busy instruction -> second instruction accepted only in IDLE. Assert rst_n=0 during MEM -> mem_req=0 immediately; regs, flags and err all 0.
- Opcode 15 -> err=1 sticky, done pulse, no regfile change. With ALU_SEQ_CTRL_TIMEOUT_EN and MEM_TIMEOUT=8, LD with no ack -> abort after 8 cycles, err=1.
